// File: rtl/ijvm_pkg.sv
// Shared definitions for the IJVM memory bridge: FSM encoding, word geometry
// and big-endian byte selection.
package ijvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD  = 2'd1,
    FETCH = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // IJVM is big-endian: offset 0 is the most significant byte.
  function automatic logic [7:0] ijvm_byte_sel(input logic [31:0] word, input logic [1:0] offset);
    logic [7:0] sel;
    case (offset)
      2'd0:    sel = word[31:24];
      2'd1:    sel = word[23:16];
      2'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ijvm_fetch_buf.sv
// One-word opcode fetch buffer: tag/data/valid, hit compare against the PC,
// byte select, and invalidation by a write to the buffered word.
module ijvm_fetch_buf
  import ijvm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [7:0]        hit_byte,
  input  logic              fill_en,
  input  logic [ADDR_W-3:0] fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval_en,
  input  logic [ADDR_W-3:0] inval_word
);

  logic [ADDR_W-3:0] tag_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (fill_en) begin
      tag_reg   <= fill_tag;
      data_reg  <= fill_data;
      valid_reg <= 1'b1;
    end else if (inval_en && (inval_word == tag_reg)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit      = valid_reg && (lookup_addr[ADDR_W-1:2] == tag_reg);
  assign hit_byte = ijvm_byte_sel(data_reg, lookup_addr[1:0]);

endmodule

// File: rtl/ijvm_mem_bridge.sv
// Bridges the IJVM MAR/MDR word port and PC/MBR byte-fetch port onto one
// single-port req/ack memory, stalling the processor while an access is open.
module ijvm_mem_bridge
  import ijvm_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] word_address,
  inout  wire  [DATA_W-1:0] word_data,
  input  logic [ADDR_W-1:0] byte_address,
  output logic [7:0]        byte_data,
  input  logic              read,
  input  logic              write,
  input  logic              fetch,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic              word_pend_reg, fetch_pend_reg, is_write_reg;
  logic [ADDR_W-3:0] word_addr_reg;
  logic [DATA_W-1:0] wdata_reg, rd_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;
  logic              drive_en_reg, stall_reg, err_reg;
  logic [7:0]        byte_data_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              buf_hit;
  logic [7:0]        buf_byte;
  logic              word_accept, fetch_hit, fetch_miss;
  logic              busy, expire, word_done, fetch_done;
  logic [DATA_W-1:0] done_data;

  // The top two MAR bits fall off the word-to-byte shift.
  wire unused_addr_bits = ^word_address[ADDR_W-1:ADDR_W-2];

  assign word_accept = ~stall_reg & (read | write);
  assign fetch_hit   = ~stall_reg & fetch & buf_hit;
  assign fetch_miss  = ~stall_reg & fetch & ~buf_hit;

  assign busy       = (state_reg != IDLE);
  assign expire     = busy & ~mem_ack & (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign word_done  = (state_reg == WORD) & (mem_ack | expire);
  assign fetch_done = (state_reg == FETCH) & (mem_ack | expire);
  assign done_data  = mem_ack ? mem_rdata : '0;

  ijvm_fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .lookup_addr(byte_address),
    .hit        (buf_hit),
    .hit_byte   (buf_byte),
    .fill_en    (fetch_done & mem_ack),
    .fill_tag   (fetch_addr_reg[ADDR_W-1:2]),
    .fill_data  (mem_rdata),
    .inval_en   (word_done & is_write_reg),
    .inval_word (word_addr_reg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (word_pend_reg) state_next = WORD;
               else if (fetch_pend_reg) state_next = FETCH;
      WORD:    if (word_done) state_next = fetch_pend_reg ? FETCH : IDLE;
      FETCH:   if (fetch_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      WORD: begin
        mem_req   = 1'b1;
        mem_we    = is_write_reg;
        mem_addr  = {word_addr_reg, 2'b00};
        mem_wdata = is_write_reg ? wdata_reg : '0;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {fetch_addr_reg[ADDR_W-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Completion terms come last so they override the acceptance terms; the two
  // never coincide because acceptance requires stall low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_pend_reg  <= 1'b0;
      fetch_pend_reg <= 1'b0;
      is_write_reg   <= 1'b0;
      word_addr_reg  <= '0;
      wdata_reg      <= '0;
      fetch_addr_reg <= '0;
      rd_reg         <= '0;
      drive_en_reg   <= 1'b0;
      stall_reg      <= 1'b0;
      err_reg        <= 1'b0;
      byte_data_reg  <= '0;
      cnt_reg        <= '0;
    end else begin
      if (word_accept) begin
        word_pend_reg <= 1'b1;
        is_write_reg  <= write;
        word_addr_reg <= word_address[ADDR_W-3:0];
        wdata_reg     <= word_data;
        if (write) drive_en_reg <= 1'b0;
        if (read && write) err_reg <= 1'b1;
      end
      if (fetch_miss) begin
        fetch_pend_reg <= 1'b1;
        fetch_addr_reg <= byte_address;
      end
      if (fetch_hit) byte_data_reg <= buf_byte;
      if (word_accept || fetch_miss) stall_reg <= 1'b1;
      if (expire) err_reg <= 1'b1;

      if (word_done) begin
        word_pend_reg <= 1'b0;
        if (!is_write_reg) begin
          rd_reg       <= done_data;
          drive_en_reg <= 1'b1;
        end
        if (!fetch_pend_reg) stall_reg <= 1'b0;
      end
      if (fetch_done) begin
        fetch_pend_reg <= 1'b0;
        byte_data_reg  <= ijvm_byte_sel(done_data, fetch_addr_reg[1:0]);
        stall_reg      <= 1'b0;
      end

      if (busy && !mem_ack && !expire) cnt_reg <= cnt_reg + 1'b1;
      else                             cnt_reg <= '0;
    end
  end

  assign word_data = (drive_en_reg && !write) ? rd_reg : 'z;
  assign byte_data = byte_data_reg;
  assign stall     = stall_reg;
  assign err       = err_reg;

endmodule
